// File: rtl/filter_iir_sos_tdm.sv
// Cascaded Direct Form 1 biquad IIR filter. One multiplier is time-shared over all sections and channels.
// Defining FILTER_IIR_SOS_TDM_ROUND_EN rounds half up before the output shift; otherwise the shift floors.
module filter_iir_sos_tdm #(
  parameter int BIT_WIDTH    = 16,
  parameter int BIT_FRAC     = 14,
  parameter int NUM_SECTIONS = 2,
  parameter int NUM_CHANNELS = 2,
  parameter int UINT_IO      = 0,
  localparam int CH_W        = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                                CLK,
  input  logic                                nRST,
  input  logic [NUM_SECTIONS*5*BIT_WIDTH-1:0] FILT_COEFF,
  input  logic                                IN_VALID,
  output logic                                IN_READY,
  input  logic [CH_W-1:0]                     IN_CH,
  input  logic [BIT_WIDTH-1:0]                DATA_IN,
  output logic                                OUT_VALID,
  output logic [CH_W-1:0]                     OUT_CH,
  output logic [BIT_WIDTH-1:0]                DATA_OUT
);

  localparam int BW    = BIT_WIDTH;
  localparam int SEC_W = (NUM_SECTIONS > 1) ? $clog2(NUM_SECTIONS) : 1;
  localparam int ACC_W = 2*BW + 3;
  // A single section or channel still gets two tap rows, so each index width matches its array depth.
  localparam int CH_D  = (NUM_CHANNELS > 1) ? NUM_CHANNELS : 2;
  localparam int SEC_D = (NUM_SECTIONS > 1) ? NUM_SECTIONS : 2;

  localparam logic [SEC_W-1:0] LAST_SEC = SEC_W'(NUM_SECTIONS - 1);
  localparam logic [CH_W:0]    NUM_CH   = (CH_W+1)'(NUM_CHANNELS);
  localparam logic [BW-1:0]    IO_FLIP  = (UINT_IO != 0) ? {1'b1, {(BW-1){1'b0}}} : '0;
  localparam logic signed [ACC_W-1:0] Y_MAX = {{(ACC_W-BW+1){1'b0}}, {(BW-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] Y_MIN = {{(ACC_W-BW+1){1'b1}}, {(BW-1){1'b0}}};
`ifdef FILTER_IIR_SOS_TDM_ROUND_EN
  localparam logic signed [ACC_W-1:0] RND_C = {{(ACC_W-1){1'b0}}, 1'b1} << (BIT_FRAC - 1);
`endif

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_WB, S_DONE} state_t;

  state_t                   state;
  logic [CH_W-1:0]          ch_q;
  logic [SEC_W-1:0]         sec_q;
  logic [2:0]               step;
  logic [BW-1:0]            x_cur;
  logic signed [ACC_W-1:0]  acc;

  logic [BW-1:0] x1_mem [CH_D][SEC_D];
  logic [BW-1:0] x2_mem [CH_D][SEC_D];
  logic [BW-1:0] y1_mem [CH_D][SEC_D];
  logic [BW-1:0] y2_mem [CH_D][SEC_D];

  logic [BW-1:0]           coef;
  logic [BW-1:0]           op;
  logic [2*BW-1:0]         prod;
  logic signed [ACC_W-1:0] acc_r;
  logic signed [ACC_W-1:0] acc_sh;
  logic [BW-1:0]           y_sat;

  // NOTE: always_comb assigns every output first so no path can leave a latch behind.
  always_comb begin
    coef = FILT_COEFF[(int'(sec_q)*5 + int'(step))*BW +: BW];
    op   = x_cur;
    case (step)
      3'd1:    op = x1_mem[ch_q][sec_q];
      3'd2:    op = x2_mem[ch_q][sec_q];
      3'd3:    op = y1_mem[ch_q][sec_q];
      3'd4:    op = y2_mem[ch_q][sec_q];
      default: op = x_cur;
    endcase
    // Sign-extend both operands, so the low 2*BW bits hold the exact signed product.
    prod = {{BW{coef[BW-1]}}, coef} * {{BW{op[BW-1]}}, op};

    acc_r = acc;
`ifdef FILTER_IIR_SOS_TDM_ROUND_EN
    acc_r = acc + RND_C;
`endif
    acc_sh = acc_r >>> BIT_FRAC;
    if (acc_sh > Y_MAX)      y_sat = {1'b0, {(BW-1){1'b1}}};
    else if (acc_sh < Y_MIN) y_sat = {1'b1, {(BW-1){1'b0}}};
    else                     y_sat = acc_sh[BW-1:0];
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state     <= S_IDLE;
      ch_q      <= '0;
      sec_q     <= '0;
      step      <= '0;
      x_cur     <= '0;
      acc       <= '0;
      IN_READY  <= 1'b0;
      OUT_VALID <= 1'b0;
      OUT_CH    <= '0;
      DATA_OUT  <= '0;
      // NOTE: the tap arrays are reset on purpose, so a filter restarts from a zero history after reset.
      for (int c = 0; c < CH_D; c++) begin
        for (int s = 0; s < SEC_D; s++) begin
          x1_mem[c][s] <= '0;
          x2_mem[c][s] <= '0;
          y1_mem[c][s] <= '0;
          y2_mem[c][s] <= '0;
        end
      end
    end else begin
      OUT_VALID <= 1'b0;
      case (state)
        S_IDLE: begin
          IN_READY <= 1'b1;
          // A sample for a channel that does not exist is consumed and dropped. The filter stays ready.
          if (IN_READY && IN_VALID && ({1'b0, IN_CH} < NUM_CH)) begin
            ch_q     <= IN_CH;
            x_cur    <= DATA_IN ^ IO_FLIP;
            acc      <= '0;
            sec_q    <= '0;
            step     <= '0;
            IN_READY <= 1'b0;
            state    <= S_MAC;
          end
        end
        S_MAC: begin
          acc <= acc + {{(ACC_W-2*BW){prod[2*BW-1]}}, prod};
          if (step == 3'd4) begin
            step  <= '0;
            state <= S_WB;
          end else begin
            step <= step + 3'd1;
          end
        end
        S_WB: begin
          x2_mem[ch_q][sec_q] <= x1_mem[ch_q][sec_q];
          x1_mem[ch_q][sec_q] <= x_cur;
          y2_mem[ch_q][sec_q] <= y1_mem[ch_q][sec_q];
          y1_mem[ch_q][sec_q] <= y_sat;
          x_cur               <= y_sat;
          if (sec_q == LAST_SEC) begin
            OUT_VALID <= 1'b1;
            OUT_CH    <= ch_q;
            DATA_OUT  <= y_sat ^ IO_FLIP;
            state     <= S_DONE;
          end else begin
            sec_q <= sec_q + 1'b1;
            acc   <= '0;
            state <= S_MAC;
          end
        end
        S_DONE: begin
          IN_READY <= 1'b1;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
